// File: rtl/memio_timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL bit positions, window match and byte-strobe merge.
`define MEMIO_TIMER_IN_WINDOW(addr, base) ((addr[31:5]) == (base[31:5]))

package memio_timer_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_RELOAD = 3'd3;
    localparam logic [2:0] REG_PRESC  = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IEN  = 2;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/memio_timer_if.sv
// PicoRV32 native memory bus as seen by one responder.
interface memio_timer_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/memio_timer_presc.sv
// Prescaler: emits a one-cycle tick every presc+1 enabled clocks.
module memio_timer_presc #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == presc);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (tick) cnt_reg <= '0;
            else      cnt_reg <= cnt_reg + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/memio_timer.sv
// Memory-mapped down-counting timer on the PicoRV32 native bus;
// periodic or one-shot expiry raises PEND, irq = PEND & IEN.
module memio_timer
    import memio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          PRESC_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    memio_timer_if.slave     bus,
    input  logic             eoi,
    output logic             irq
);

    logic [2:0]         ctrl_reg,   ctrl_next;
    logic               pend_reg,   pend_next;
    logic [31:0]        count_reg,  count_next;
    logic [31:0]        reload_reg, reload_next;
    logic [PRESC_W-1:0] presc_reg,  presc_next;
    logic               ready_reg;
    logic [31:0]        rdata_reg;

    logic        sel, wr, tick, expire, w1c, en_rise;
    logic [2:0]  off;
    logic [31:0] rd_val, ctrl_wr, presc_wr;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, bus.mem_addr[1:0]};

    // ready_reg gates sel so a request still held during its ack is not re-served
    assign sel     = bus.mem_valid && `MEMIO_TIMER_IN_WINDOW(bus.mem_addr, BASE_ADDR) && !ready_reg;
    assign wr      = sel && (bus.mem_wstrb != 4'b0000);
    assign off     = bus.mem_addr[4:2];
    assign w1c     = wr && (off == REG_STATUS) && bus.mem_wstrb[0] && bus.mem_wdata[0];
    assign en_rise = wr && (off == REG_CTRL) && bus.mem_wstrb[0]
                     && bus.mem_wdata[CTRL_EN] && !ctrl_reg[CTRL_EN];
    assign expire  = tick && (count_reg == 32'd0);

    memio_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk    (clk),
        .resetn (resetn),
        .en     (ctrl_reg[CTRL_EN]),
        .clear  (en_rise),
        .presc  (presc_reg),
        .tick   (tick)
    );

    always_comb begin
        ctrl_next   = ctrl_reg;
        pend_next   = pend_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        presc_next  = presc_reg;
        ctrl_wr     = merge_bytes({29'd0, ctrl_reg}, bus.mem_wdata, bus.mem_wstrb);
        presc_wr    = merge_bytes(32'(presc_reg), bus.mem_wdata, bus.mem_wstrb);

        if (tick) begin
            if (count_reg != 32'd0)      count_next = count_reg - 32'd1;
            else if (ctrl_reg[CTRL_AUTO]) count_next = reload_reg;
            else                          ctrl_next[CTRL_EN] = 1'b0;
        end

        // bus writes are applied after the counter update so they win
        if (wr) begin
            case (off)
                REG_CTRL:   ctrl_next   = ctrl_wr[2:0];
                REG_COUNT:  count_next  = merge_bytes(count_reg, bus.mem_wdata, bus.mem_wstrb);
                REG_RELOAD: reload_next = merge_bytes(reload_reg, bus.mem_wdata, bus.mem_wstrb);
                REG_PRESC:  presc_next  = presc_wr[PRESC_W-1:0];
                default:    ;
            endcase
        end

        if (w1c || eoi) pend_next = 1'b0;
        if (expire)     pend_next = 1'b1;
    end

    always_comb begin
        rd_val = 32'd0;
        case (off)
            REG_CTRL:   rd_val = {29'd0, ctrl_reg};
            REG_STATUS: rd_val = {31'd0, pend_reg};
            REG_COUNT:  rd_val = count_reg;
            REG_RELOAD: rd_val = reload_reg;
            REG_PRESC:  rd_val = 32'(presc_reg);
            default:    rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_reg   <= '0;
            pend_reg   <= 1'b0;
            count_reg  <= '0;
            reload_reg <= '0;
            presc_reg  <= '0;
            ready_reg  <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            ctrl_reg   <= ctrl_next;
            pend_reg   <= pend_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            presc_reg  <= presc_next;
            ready_reg  <= sel;
            rdata_reg  <= sel ? rd_val : 32'd0;
        end
    end

    assign bus.mem_ready = ready_reg;
    assign bus.mem_rdata = rdata_reg;
    assign irq           = pend_reg & ctrl_reg[CTRL_IEN];

endmodule

// File: tb/tb_memio_timer.sv
// Scoreboard bench for memio_timer: reads push expected data, the negedge
// monitor pops and compares on every mem_ready.
module tb_memio_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          is_read;
    } sb_t;

    logic clk;
    logic resetn;
    logic eoi;
    logic irq;
    int   cyc = 0;
    int   last_commit = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    sb_t  sb[$];

    memio_timer_if bus();

    memio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .eoi    (eoi),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.is_read) chk(e.tag, bus.mem_rdata, e.exp);
            end
        end
    end

    task automatic bus_xfer(input string tag, input logic [7:0] off, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp, input bit hold);
        sb_t e;
        int  lat;
        bit  got;
        e.tag = tag; e.exp = exp; e.is_read = (wstrb == 4'b0000);
        sb.push_back(e);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + {24'd0, off};
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_ready) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd1);
        if (!got) void'(sb.pop_back());
        last_commit = cyc;
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, "_noreack"}, {31'd0, bus.mem_ready}, 32'd0);
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int target);
        if (cyc > target) chk("sched_late", 32'(cyc), 32'(target));
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic poll_irq(output int rise);
        rise = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (irq) begin
                rise = cyc;
                break;
            end
        end
        if (rise < 0) chk("irq_timeout", 32'd0, 32'd1);
    endtask

    int r1, r2, os_cyc, en_cyc, ros;

    initial begin
        resetn = 1'b0; eoi = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_irq",   {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        bus_xfer("idle_ctrl", 8'h00, 32'd0, 4'h0, 32'd0, 1'b1);
        for (int i = 1; i <= 4; i++) bus_xfer("idle_reg", 8'(i * 4), 32'd0, 4'h0, 32'd0, 1'b0);
        chk("idle_irq", {31'd0, irq}, 32'd0);

        // periodic: (4+1)*(3+1) = 20 clocks per expiry
        bus_xfer("wr_presc",  8'h10, 32'd3, 4'hF, 32'd0, 1'b0);
        bus_xfer("wr_reload", 8'h0C, 32'd4, 4'hF, 32'd0, 1'b0);
        bus_xfer("wr_count",  8'h08, 32'd4, 4'hF, 32'd0, 1'b0);
        bus_xfer("wr_ctrl",   8'h00, 32'd7, 4'hF, 32'd0, 1'b0);
        en_cyc = last_commit;
        poll_irq(r1);
        chk("per_first", 32'(r1 - en_cyc), 32'd20);
        bus_xfer("w1c", 8'h04, 32'd1, 4'h1, 32'd0, 1'b0);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        poll_irq(r2);
        chk("per_period", 32'(r2 - r1), 32'd20);
        for (int k = 0; k < 4; k++) begin
            wait_until(r2 + 4 * k);
            bus_xfer("cnt_seq", 8'h08, 32'd0, 4'h0, 32'(4 - k), 1'b0);
        end
        wait_until(r2 + 14);
        bus_xfer("w1c2", 8'h04, 32'd1, 4'h1, 32'd0, 1'b0);
        chk("w1c2_irq", {31'd0, irq}, 32'd0);
        wait_until(r2 + 16);
        bus_xfer("cnt_zero", 8'h08, 32'd0, 4'h0, 32'd0, 1'b0);
        wait_until(r2 + 19);
        bus_xfer("w1c_collide", 8'h04, 32'd1, 4'h1, 32'd0, 1'b0);
        chk("collide_irq", {31'd0, irq}, 32'd1);
        bus_xfer("collide_pend", 8'h04, 32'd0, 4'h0, 32'd1, 1'b0);
        wait_until(r2 + 23);
        bus_xfer("cnt_wr_tick", 8'h08, 32'd9, 4'hF, 32'd0, 1'b0);
        bus_xfer("cnt_wr_rd", 8'h08, 32'd0, 4'h0, 32'd9, 1'b0);
        bus_xfer("stop", 8'h00, 32'd0, 4'hF, 32'd0, 1'b0);
        eoi = 1'b1;
        @(posedge clk); #1;
        eoi = 1'b0;
        bus_xfer("eoi_pend", 8'h04, 32'd0, 4'h0, 32'd0, 1'b0);
        chk("eoi_irq", {31'd0, irq}, 32'd0);

        // one-shot
        bus_xfer("os_presc", 8'h10, 32'd0, 4'hF, 32'd0, 1'b0);
        bus_xfer("os_count", 8'h08, 32'd2, 4'hF, 32'd0, 1'b0);
        bus_xfer("os_ctrl",  8'h00, 32'd5, 4'hF, 32'd0, 1'b0);
        os_cyc = last_commit;
        poll_irq(ros);
        chk("os_delay", 32'(ros - os_cyc), 32'd3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus_xfer("os_pend",  8'h04, 32'd0, 4'h0, 32'd1, 1'b0);
        bus_xfer("os_ctrl_rd", 8'h00, 32'd0, 4'h0, 32'd4, 1'b0);
        bus_xfer("os_count_rd", 8'h08, 32'd0, 4'h0, 32'd0, 1'b0);
        chk("os_irq", {31'd0, irq}, 32'd1);

        // byte strobes and unmapped offsets
        bus_xfer("bs_clr", 8'h0C, 32'd0, 4'hF, 32'd0, 1'b0);
        bus_xfer("bs_wr",  8'h0C, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
        bus_xfer("bs_rd",  8'h0C, 32'd0, 4'h0, 32'h00BB_00DD, 1'b0);
        bus_xfer("unm_wr", 8'h1C, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
        bus_xfer("unm_rd", 8'h1C, 32'd0, 4'h0, 32'd0, 1'b0);
        bus_xfer("unm_rd14", 8'h14, 32'd0, 4'h0, 32'd0, 1'b0);

        // asynchronous reset while an ack is on the bus and irq is high
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'h08;
        bus.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("ar_ready_pre", {31'd0, bus.mem_ready}, 32'd1);
        chk("ar_irq_pre",   {31'd0, irq}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("ar_irq",   {31'd0, irq}, 32'd0);
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i <= 4; i++) bus_xfer("post_rst", 8'(i * 4), 32'd0, 4'h0, 32'd0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
